mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised memory-access sequencer sitting between the CPU control unit/MAR-MDR path and the synchronous word memory.
- Replaces the fixed single-cycle Read/write_mem strobes with a request/acknowledge interface.
- Adds configurable wait states, incrementing bursts with address wrap, per-beat write-data handshake, abort and error reporting.

Parameters:
DATA_W, 32, data word width
ADDR_W, 9, word address width; addresses wrap modulo 2^ADDR_W
WAIT_STATES, 1, extra cycles each beat holds the memory strobe (0 = single-cycle beat)
LEN_W, 3, width of burst_len; maximum burst is 2^LEN_W-1 beats

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  start request, sampled only in IDLE
we  input  1  1 = write burst, 0 = read burst; latched with req
addr  input  ADDR_W  start word address; latched with req
burst_len  input  LEN_W  number of beats; latched with req
abort  input  1  synchronous abort of an in-progress access
wdata  input  DATA_W  write data for the current beat
wdata_ack  output  1  current write beat consumed; requester presents the next word after this edge
rdata  output  DATA_W  registered read data
rdata_valid  output  1  one-cycle pulse per completed read beat
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse
err  output  1  qualifies done: zero-length request or abort
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data (driven from wdata during write beats)
mem_rdata  input  DATA_W  memory read data, valid in the final cycle of a read beat
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (reset=0, asynchronous): state=IDLE; all counters and latches cleared.
  - All outputs are 0: rdata, rdata_valid, busy, done, err, wdata_ack, mem_addr, mem_read, mem_write.
  - mem_wdata=0 outside write beats.
  - Reset mid-access drops mem_read/mem_write immediately, with no done pulse.
- IDLE:
  - req=1 and burst_len!=0: latch we, addr into cur_addr, and burst_len into beats_left; load wait_cnt=WAIT_STATES; go to ACCESS.
  - req=1 and burst_len==0: go to DONE with err=1; no memory strobe is issued.
  - req=0: stay in IDLE.
- ACCESS (Moore outputs):
  - mem_addr=cur_addr; mem_read=~we_l; mem_write=we_l; mem_wdata=wdata when writing.
  - Each beat occupies exactly WAIT_STATES+1 cycles.
  - wait_cnt!=0: decrement it.
  - wait_cnt==0 is the beat-completion cycle:
    - Write: wdata_ack=1 combinationally.
    - Read: mem_rdata is registered into rdata, and rdata_valid=1 in the following cycle.
    - cur_addr increments modulo 2^ADDR_W (0x1FF+1 -> 0x000).
    - beats_left decrements.
    - beats_left==1 before the decrement: go to DONE.
    - Otherwise stay in ACCESS and reload wait_cnt.
- abort=1 in any ACCESS cycle:
  - Strobes drop next cycle; go to DONE with err=1.
  - The interrupted beat produces no wdata_ack, no rdata update and no rdata_valid.
  - abort takes priority over beat completion in the same cycle.
  - abort is ignored in IDLE and DONE.
- DONE: done=1 for one cycle, err as set; busy=1; then return to IDLE.
  - req asserted during ACCESS or DONE is ignored and is not queued.
- rdata holds its last value until the next read-beat completion.
- Latency: single read with WAIT_STATES=W, req in cycle 0:
  - Strobe in cycles 1..W+1.
  - rdata_valid and done both in cycle W+2.
  - busy high in cycles 1..W+2.
- Burst of N beats: done arrives N*(W+1)+1 cycles after req.

Test Plan:
- Single read, WAIT_STATES=1, addr=0x010, mem[0x010]=0xDEADBEEF -> mem_read high in cycles 1-2; rdata=0xDEADBEEF with rdata_valid=1 and done=1 in cycle 3; err=0.
- Write burst len=3 at addr=0x1FE, wdata sequence 0xA,0xB,0xC advanced on each wdata_ack -> mem writes land at 0x1FE=0xA, 0x1FF=0xB, 0x000=0xC; three wdata_ack pulses; done in cycle 7.
- Read burst len=4, WAIT_STATES=0, mem[0x20..0x23]=1,2,3,4 -> rdata_valid high in cycles 2-5 with rdata=1,2,3,4; done in cycle 5.
- burst_len=0 request -> done=1 and err=1 in cycle 1; mem_read and mem_write never asserted.
- Abort: read burst len=4, WAIT_STATES=1, abort asserted in the completion cycle of beat 2 -> only one rdata_valid pulse; strobes low next cycle; done=1 and err=1.
- reset pulled low in the middle of a write burst -> mem_write, busy, done and err go to 0 immediately; after reset release a new req at 0x005 completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-access sequencer placed between the CPU control unit (MAR/MDR path)
// and a synchronous word memory. A request starts a burst of burst_len beats
// at addr. Each beat holds the memory strobe for WAIT_STATES+1 cycles. The
// address increments after every beat and wraps modulo 2^ADDR_W. A burst ends
// with a one-cycle done pulse. err qualifies done when the request had zero
// length or was aborted.
//
// Handshake semantics: req is sampled only while the unit is idle (busy=0),
// and the request is accepted on that clock edge; a req seen while busy is
// dropped, not queued. During a write burst the requester holds wdata stable
// for the current beat. wdata_ack=1 in a cycle means that word is consumed
// at the coming edge, and the next word must be presented after that edge.
// Read beats are reported by rdata_valid, a one-cycle pulse with no
// back-pressure.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   req          in   start request (sampled in IDLE only)
//   we           in   1 = write burst, 0 = read burst (latched with req)
//   addr         in   start word address (latched with req)
//   burst_len    in   number of beats, 0 = error (latched with req)
//   abort        in   synchronous abort of an in-progress access
//   wdata        in   write data for the current beat
//   wdata_ack    out  current write beat consumed this cycle
//   rdata        out  registered read data, holds until next read beat
//   rdata_valid  out  one-cycle pulse per completed read beat
//   busy         out  state is not IDLE
//   done         out  one-cycle completion pulse
//   err          out  qualifies done: zero-length request or abort
//   mem_addr     out  memory word address
//   mem_wdata    out  memory write data (0 outside write beats)
//   mem_rdata    in   memory read data, valid in last cycle of a read beat
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   dbg_state    out  current FSM state (IDLE=0, ACCESS=1, DONE=2)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1,
  parameter int LEN_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // The wait counter keeps at least one bit so WAIT_STATES=0 still elaborates.
  localparam int WC_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(WAIT_STATES);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              err_q, err_d;

  logic in_access;
  logic beat_end;

  assign in_access = (state_q == ACCESS);
  // Last cycle of the current beat; an abort in this cycle cancels the beat.
  assign beat_end  = in_access && (wait_cnt_q == '0) && !abort;

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    cur_addr_d    = cur_addr_q;
    beats_left_d  = beats_left_q;
    wait_cnt_d    = wait_cnt_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = err_q;

    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (req) begin
          if (burst_len != '0) begin
            we_d         = we;
            cur_addr_d   = addr;
            beats_left_d = burst_len;
            wait_cnt_d   = WAIT_LOAD;
            state_d      = ACCESS;
          end else begin
            // Zero-length request: report an error without touching memory.
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      ACCESS: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WC_W'(1);
        end else begin
          if (!we_q) begin
            rdata_d       = mem_rdata;
            rdata_valid_d = 1'b1;
          end
          cur_addr_d   = cur_addr_q + ADDR_W'(1);
          beats_left_d = beats_left_q - LEN_W'(1);
          if (beats_left_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      cur_addr_q    <= '0;
      beats_left_q  <= '0;
      wait_cnt_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      cur_addr_q    <= cur_addr_d;
      beats_left_q  <= beats_left_d;
      wait_cnt_q    <= wait_cnt_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  // Memory side is driven only while in ACCESS so the bus is quiet otherwise.
  assign mem_addr    = in_access ? cur_addr_q : '0;
  assign mem_read    = in_access && !we_q;
  assign mem_write   = in_access && we_q;
  assign mem_wdata   = mem_write ? wdata : '0;
  assign wdata_ack   = beat_end && we_q;

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = (state_q == DONE) && err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Two instances share clock and reset: dut0 with one wait state and dut1 with
// none. Each instance has its own behavioural word memory. Expected read
// data, done/err pulses and write acks are queued with the absolute cycle in
// which they must appear. Per-DUT monitors pop and compare these entries on
// every falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int LW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- dut0 (WAIT_STATES=1) ----------------
  logic          req0 = 0, we0 = 0, abort0 = 0;
  logic [AW-1:0] addr0 = '0;
  logic [LW-1:0] len0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          wdata_ack0, rdata_valid0, busy0, done0, err0, mem_read0, mem_write0;
  logic [DW-1:0] rdata0, mem_wdata0, mem_rdata0;
  logic [AW-1:0] mem_addr0;
  logic [1:0]    dbg0;
  logic [DW-1:0] mem0 [512];

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(1), .LEN_W(LW)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
    .burst_len(len0), .abort(abort0), .wdata(wdata0), .wdata_ack(wdata_ack0),
    .rdata(rdata0), .rdata_valid(rdata_valid0), .busy(busy0), .done(done0),
    .err(err0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .mem_read(mem_read0), .mem_write(mem_write0),
    .dbg_state(dbg0)
  );

  assign mem_rdata0 = mem0[mem_addr0];
  always @(posedge clk) if (mem_write0) mem0[mem_addr0] = mem_wdata0;

  // ---------------- dut1 (WAIT_STATES=0) ----------------
  logic          req1 = 0, we1 = 0, abort1 = 0;
  logic [AW-1:0] addr1 = '0;
  logic [LW-1:0] len1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          wdata_ack1, rdata_valid1, busy1, done1, err1, mem_read1, mem_write1;
  logic [DW-1:0] rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0] mem_addr1;
  logic [1:0]    dbg1;
  logic [DW-1:0] mem1 [512];

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(0), .LEN_W(LW)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1),
    .burst_len(len1), .abort(abort1), .wdata(wdata1), .wdata_ack(wdata_ack1),
    .rdata(rdata1), .rdata_valid(rdata_valid1), .busy(busy1), .done(done1),
    .err(err1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_read(mem_read1), .mem_write(mem_write1),
    .dbg_state(dbg1)
  );

  assign mem_rdata1 = mem1[mem_addr1];
  always @(posedge clk) if (mem_write1) mem1[mem_addr1] = mem_wdata1;

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_pass = 0;

  // {cycle, data} for reads, {cycle, err} for done, cycle for write acks
  logic [63:0] rd_q0[$], dn_q0[$], ack_q0[$];
  logic [63:0] rd_q1[$], dn_q1[$];
  int rd_stb0 = 0, wr_stb0 = 0, rd_stb1 = 0, wr_stb1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [63:0] e0, e1;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_read0)  rd_stb0++;
      if (mem_write0) wr_stb0++;
      if (rdata_valid0) begin
        if (rd_q0.size() == 0) chk("d0 unexpected rdata_valid", 1, 0);
        else begin
          e0 = rd_q0.pop_front();
          chk("d0 rdata", 64'(rdata0), {32'd0, e0[31:0]});
          chk("d0 rdata_valid cycle", 64'(cyc), {32'd0, e0[63:32]});
        end
      end
      if (done0) begin
        if (dn_q0.size() == 0) chk("d0 unexpected done", 1, 0);
        else begin
          e0 = dn_q0.pop_front();
          chk("d0 err", 64'(err0), {32'd0, e0[31:0]});
          chk("d0 done cycle", 64'(cyc), {32'd0, e0[63:32]});
          chk("d0 busy at done", 64'(busy0), 64'd1);
        end
      end
      if (wdata_ack0) begin
        if (ack_q0.size() == 0) chk("d0 unexpected wdata_ack", 1, 0);
        else begin
          e0 = ack_q0.pop_front();
          chk("d0 wdata_ack cycle", 64'(cyc), e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (mem_read1)  rd_stb1++;
      if (mem_write1) wr_stb1++;
      if (wdata_ack1) chk("d1 unexpected wdata_ack", 1, 0);
      if (rdata_valid1) begin
        if (rd_q1.size() == 0) chk("d1 unexpected rdata_valid", 1, 0);
        else begin
          e1 = rd_q1.pop_front();
          chk("d1 rdata", 64'(rdata1), {32'd0, e1[31:0]});
          chk("d1 rdata_valid cycle", 64'(cyc), {32'd0, e1[63:32]});
        end
      end
      if (done1) begin
        if (dn_q1.size() == 0) chk("d1 unexpected done", 1, 0);
        else begin
          e1 = dn_q1.pop_front();
          chk("d1 err", 64'(err1), {32'd0, e1[31:0]});
          chk("d1 done cycle", 64'(cyc), {32'd0, e1[63:32]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raises req at a falling edge; t0 is the request cycle ("cycle 0").
  task automatic issue(input int dut, input logic w, input logic [AW-1:0] a,
                       input logic [LW-1:0] len, output int t0);
    @(negedge clk);
    if (dut == 0) begin we0 = w; addr0 = a; len0 = len; req0 = 1'b1; end
    else          begin we1 = w; addr1 = a; len1 = len; req1 = 1'b1; end
    t0 = cyc;
  endtask

  task automatic drop_req();
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] ev(input int c, input logic [31:0] v);
    return {32'(c), v};
  endfunction

  // ---------------- stimulus ----------------
  int t0;
  int idx;
  logic [DW-1:0] words [3];

  initial begin
    for (int i = 0; i < 512; i++) begin mem0[i] = '0; mem1[i] = '0; end

    // Reset state
    #3;
    chk("reset rdata", 64'(rdata0), 64'd0);
    chk("reset busy/done/err", {61'd0, busy0, done0, err0}, 64'd0);
    chk("reset strobes/ack/valid", {60'd0, mem_read0, mem_write0, wdata_ack0, rdata_valid0}, 64'd0);
    chk("reset mem_addr/mem_wdata", {23'd0, mem_addr0, mem_wdata0}, 64'd0);
    chk("d1 reset outputs", {57'd0, busy1, done1, err1, mem_read1, mem_write1,
                             wdata_ack1, rdata_valid1}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Single read, one wait state
    mem0[9'h010] = 32'hDEADBEEF;
    rd_stb0 = 0;
    issue(0, 1'b0, 9'h010, 3'd1, t0);
    rd_q0.push_back(ev(t0 + 3, 32'hDEADBEEF));
    dn_q0.push_back(ev(t0 + 3, 32'd0));
    drop_req();
    chk("single read busy cycle 1", 64'(busy0), 64'd1);
    idle(6);
    chk("single read strobe cycles", 64'(rd_stb0), 64'd2);
    chk("single read rdata holds", 64'(rdata0), 64'hDEADBEEF);

    // Write burst of 3 across the address wrap
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    wr_stb0 = 0;
    wdata0 = words[0];
    idx = 0;
    issue(0, 1'b1, 9'h1FE, 3'd3, t0);
    ack_q0.push_back(ev(0, t0 + 2));
    ack_q0.push_back(ev(0, t0 + 4));
    ack_q0.push_back(ev(0, t0 + 6));
    dn_q0.push_back(ev(t0 + 7, 32'd0));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req0 = 1'b0;
      if (wdata_ack0 && idx < 2) begin
        @(posedge clk);
        #1;
        idx++;
        wdata0 = words[idx];
      end
    end
    chk("write mem[1FE]", 64'(mem0[9'h1FE]), 64'hA);
    chk("write mem[1FF]", 64'(mem0[9'h1FF]), 64'hB);
    chk("write mem[000] after wrap", 64'(mem0[9'h000]), 64'hC);
    chk("write strobe cycles", 64'(wr_stb0), 64'd6);
    chk("write ack queue drained", 64'(ack_q0.size()), 64'd0);

    // Zero-length request
    rd_stb0 = 0; wr_stb0 = 0;
    issue(0, 1'b0, 9'h033, 3'd0, t0);
    dn_q0.push_back(ev(t0 + 1, 32'd1));
    drop_req();
    idle(4);
    chk("zero-length no strobes", 64'(rd_stb0 + wr_stb0), 64'd0);

    // Abort in the completion cycle of beat 2 of a 4-beat read
    mem0[9'h040] = 32'h11; mem0[9'h041] = 32'h22;
    mem0[9'h042] = 32'h33; mem0[9'h043] = 32'h44;
    rd_stb0 = 0;
    issue(0, 1'b0, 9'h040, 3'd4, t0);
    rd_q0.push_back(ev(t0 + 3, 32'h11));
    dn_q0.push_back(ev(t0 + 5, 32'd1));
    drop_req();
    idle(3);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort strobe low next cycle", 64'(mem_read0), 64'd0);
    idle(4);
    chk("abort strobe cycles", 64'(rd_stb0), 64'd4);
    chk("abort rdata not updated", 64'(rdata0), 64'h11);

    // Read burst of 4, zero wait states (dut1)
    mem1[9'h020] = 32'd1; mem1[9'h021] = 32'd2;
    mem1[9'h022] = 32'd3; mem1[9'h023] = 32'd4;
    rd_stb1 = 0;
    issue(1, 1'b0, 9'h020, 3'd4, t0);
    for (int k = 0; k < 4; k++) rd_q1.push_back(ev(t0 + 2 + k, 32'(k + 1)));
    dn_q1.push_back(ev(t0 + 5, 32'd0));
    drop_req();
    idle(7);
    chk("d1 read strobe cycles", 64'(rd_stb1), 64'd4);
    chk("d1 rdata holds", 64'(rdata1), 64'd4);

    // Reset in the middle of a write burst, then a normal single write
    wdata0 = 32'h77;
    issue(0, 1'b1, 9'h100, 3'd3, t0);
    drop_req();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("reset mid-burst mem_write", 64'(mem_write0), 64'd0);
    chk("reset mid-burst busy/done/err", {61'd0, busy0, done0, err0}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    wdata0 = 32'h55;
    wr_stb0 = 0;
    issue(0, 1'b1, 9'h005, 3'd1, t0);
    ack_q0.push_back(ev(0, t0 + 2));
    dn_q0.push_back(ev(t0 + 3, 32'd0));
    drop_req();
    idle(5);
    chk("post-reset write mem[005]", 64'(mem0[9'h005]), 64'h55);
    chk("post-reset write strobes", 64'(wr_stb0), 64'd2);

    // Every queued expectation must have been matched
    chk("d0 pending expectations", 64'(rd_q0.size() + dn_q0.size() + ack_q0.size()), 64'd0);
    chk("d1 pending expectations", 64'(rd_q1.size() + dn_q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
